// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache and dcache,
// with starvation guard and tag-based return routing.
//
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   icache2mem_*             : icache request (command, addr)
//   dcache2mem_*             : dcache request (command, addr, data)
//   proc2mem_*               : arbitrated request to memory
//   mem2proc_response        : accept tag for this cycle's command (0 = reject)
//   mem2proc_data/_tag       : load return (tag 0 = nothing)
//   mem2icache_*/mem2dcache_*: routed response, data and tag
//   mem_tag_error            : return tag had no recorded owner
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      icache2mem_command,
    input  logic [XLEN-1:0] icache2mem_addr,
    input  logic [1:0]      dcache2mem_command,
    input  logic [XLEN-1:0] dcache2mem_addr,
    input  logic [63:0]     dcache2mem_data,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [3:0]      mem2icache_response,
    output logic [63:0]     mem2icache_data,
    output logic [3:0]      mem2icache_tag,
    output logic [3:0]      mem2dcache_response,
    output logic [63:0]     mem2dcache_data,
    output logic [3:0]      mem2dcache_tag,
    output logic            mem_tag_error
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2,
        BUS_RSVD  = 2'd3
    } bus_cmd_e;

    logic        ic_req;
    logic        dc_req;
    logic        starved;
    logic        grant_ic;
    logic        grant_dc;
    logic [2:0]  starve_cnt;
    logic [15:0] tag_valid;
    logic [15:0] tag_owner;   // 1 = dcache, 0 = icache
    logic        ret_live;
    logic        ret_hit;
    logic        alloc;

    // Encoding 3 is reserved and behaves as no request.
    always_comb begin
        ic_req   = (icache2mem_command == BUS_LOAD);
        dc_req   = (dcache2mem_command == BUS_LOAD) ||
                   (dcache2mem_command == BUS_STORE);
        starved  = (starve_cnt >= 3'(STARVE_LIMIT));
        grant_dc = !reset && dc_req && !(ic_req && starved);
        grant_ic = !reset && ic_req && !grant_dc;
    end

    always_comb begin
        proc2mem_command    = BUS_NONE;
        proc2mem_addr       = '0;
        proc2mem_data       = '0;
        mem2icache_response = '0;
        mem2dcache_response = '0;
        if (grant_dc) begin
            proc2mem_command    = dcache2mem_command;
            proc2mem_addr       = dcache2mem_addr;
            proc2mem_data       = dcache2mem_data;
            mem2dcache_response = mem2proc_response;
        end else if (grant_ic) begin
            proc2mem_command    = BUS_LOAD;
            proc2mem_addr       = icache2mem_addr;
            mem2icache_response = mem2proc_response;
        end
    end

    // Return routing looks only at the table as it stood before this edge,
    // so a same-cycle reallocation of the tag cannot steal the return.
    always_comb begin
        ret_live        = !reset && (mem2proc_tag != 4'd0);
        ret_hit         = ret_live && tag_valid[mem2proc_tag];
        mem_tag_error   = ret_live && !tag_valid[mem2proc_tag];
        mem2icache_tag  = '0;
        mem2icache_data = '0;
        mem2dcache_tag  = '0;
        mem2dcache_data = '0;
        if (ret_hit) begin
            if (tag_owner[mem2proc_tag]) begin
                mem2dcache_tag  = mem2proc_tag;
                mem2dcache_data = mem2proc_data;
            end else begin
                mem2icache_tag  = mem2proc_tag;
                mem2icache_data = mem2proc_data;
            end
        end
        alloc = (proc2mem_command == BUS_LOAD) &&
                (mem2proc_response != 4'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
            tag_valid  <= '0;
            tag_owner  <= '0;
        end else begin
            if (!ic_req || grant_ic)
                starve_cnt <= '0;
            else if (starve_cnt != 3'd7)
                starve_cnt <= starve_cnt + 3'd1;
            if (ret_hit)
                tag_valid[mem2proc_tag] <= 1'b0;
            // Later assignment wins: a new owner overrides the clear.
            if (alloc) begin
                tag_valid[mem2proc_response] <= 1'b1;
                tag_owner[mem2proc_response] <= grant_dc;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic
// checked against a tag-ownership reference model.
module tb_mem_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 3;

    logic            clock;
    logic            reset;
    logic [1:0]      ic_cmd;
    logic [XLEN-1:0] ic_addr;
    logic [1:0]      dc_cmd;
    logic [XLEN-1:0] dc_addr;
    logic [63:0]     dc_data;
    logic [1:0]      p_cmd;
    logic [XLEN-1:0] p_addr;
    logic [63:0]     p_data;
    logic [3:0]      m_resp;
    logic [63:0]     m_data;
    logic [3:0]      m_tag;
    logic [3:0]      i_resp;
    logic [63:0]     i_data;
    logic [3:0]      i_tag;
    logic [3:0]      d_resp;
    logic [63:0]     d_data;
    logic [3:0]      d_tag;
    logic            tag_err;

    mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clock               (clock),
        .reset               (reset),
        .icache2mem_command  (ic_cmd),
        .icache2mem_addr     (ic_addr),
        .dcache2mem_command  (dc_cmd),
        .dcache2mem_addr     (dc_addr),
        .dcache2mem_data     (dc_data),
        .proc2mem_command    (p_cmd),
        .proc2mem_addr       (p_addr),
        .proc2mem_data       (p_data),
        .mem2proc_response   (m_resp),
        .mem2proc_data       (m_data),
        .mem2proc_tag        (m_tag),
        .mem2icache_response (i_resp),
        .mem2icache_data     (i_data),
        .mem2icache_tag      (i_tag),
        .mem2dcache_response (d_resp),
        .mem2dcache_data     (d_data),
        .mem2dcache_tag      (d_tag),
        .mem_tag_error       (tag_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns each tag (0 none, 1 icache, 2 dcache)
    // and how many cycles in a row the icache has been passed over.
    int owner[16];
    int starve;
    int cur_grant;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset   = 1'b0;
        ic_cmd  = 2'd0;
        ic_addr = '0;
        dc_cmd  = 2'd0;
        dc_addr = '0;
        dc_data = '0;
        m_resp  = '0;
        m_data  = '0;
        m_tag   = '0;
    endtask

    task automatic cyc(input string w);
        logic [63:0] ecmd, eaddr, edata, eir, edr;
        logic [63:0] eit, eid, edt, edd, eerr;
        bit icr, dcr;
        int g;
        #1;
        ecmd = 0; eaddr = 0; edata = 0; eir = 0; edr = 0;
        eit = 0; eid = 0; edt = 0; edd = 0; eerr = 0;
        icr = (ic_cmd == 2'd1);
        dcr = (dc_cmd == 2'd1) || (dc_cmd == 2'd2);
        g = 0;
        if (!reset) begin
            if (dcr && !(icr && starve >= LIMIT)) g = 2;
            else if (icr) g = 1;
            if (g == 2) begin
                ecmd = dc_cmd; eaddr = dc_addr;
                edata = dc_data; edr = m_resp;
            end else if (g == 1) begin
                ecmd = 1; eaddr = ic_addr; eir = m_resp;
            end
            if (m_tag != 0) begin
                if (owner[m_tag] == 1) begin
                    eit = m_tag; eid = m_data;
                end else if (owner[m_tag] == 2) begin
                    edt = m_tag; edd = m_data;
                end else begin
                    eerr = 1;
                end
            end
        end
        cur_grant = g;
        check({w, ".cmd"}, p_cmd, ecmd);
        check({w, ".addr"}, p_addr, eaddr);
        check({w, ".pdata"}, p_data, edata);
        check({w, ".iresp"}, i_resp, eir);
        check({w, ".dresp"}, d_resp, edr);
        check({w, ".itag"}, i_tag, eit);
        check({w, ".idata"}, i_data, eid);
        check({w, ".dtag"}, d_tag, edt);
        check({w, ".ddata"}, d_data, edd);
        check({w, ".err"}, tag_err, eerr);
    endtask

    task automatic commit();
        if (reset) begin
            starve = 0;
            for (int i = 0; i < 16; i++) owner[i] = 0;
        end else begin
            if (m_tag != 0 && owner[m_tag] != 0) owner[m_tag] = 0;
            if (cur_grant != 0 && m_resp != 0 &&
                ((cur_grant == 1) || dc_cmd == 2'd1))
                owner[m_resp] = cur_grant;
            if (ic_cmd != 2'd1 || cur_grant == 1) starve = 0;
            else if (starve < 7) starve++;
        end
        @(negedge clock);
    endtask

    initial begin
        starve = 0;
        for (int i = 0; i < 16; i++) owner[i] = 0;
        idle();
        reset = 1'b1;
        cyc("rst");
        commit();

        // Icache-only load and its return.
        idle();
        ic_cmd = 2'd1; ic_addr = 'h100; m_resp = 4'd1;
        cyc("r033a");
        check("r033.addr", p_addr, 'h100);
        check("r033.iresp", i_resp, 1);
        commit();
        for (int i = 0; i < 2; i++) begin
            idle(); cyc("r033w"); commit();
        end
        idle();
        m_tag = 4'd1; m_data = 64'h12345678abcdef01;
        cyc("r033r");
        check("r033.itag", i_tag, 1);
        check("r033.idata", i_data, 64'h12345678abcdef01);
        check("r033.dtag", d_tag, 0);
        commit();

        // Starvation guard: icache wins on the fourth attempt.
        idle();
        ic_cmd = 2'd1; ic_addr = 'h1C0;
        dc_cmd = 2'd1; dc_addr = 'hD00;
        for (int i = 1; i <= 5; i++) begin
            cyc("r034");
            check("r034.grant", p_addr, (i == 4) ? 'h1C0 : 'hD00);
            commit();
        end

        // Store gets no owner entry.
        idle();
        dc_cmd = 2'd2; dc_addr = 'h200; dc_data = 'hAA; m_resp = 4'd2;
        cyc("r035a");
        check("r035.cmd", p_cmd, 2);
        check("r035.data", p_data, 'hAA);
        check("r035.dresp", d_resp, 2);
        commit();
        idle(); cyc("r035w"); commit();
        idle(); m_tag = 4'd2; m_data = 'h55;
        cyc("r035r");
        check("r035.err", tag_err, 1);
        check("r035.tags", {i_tag, d_tag}, 0);
        commit();

        // Same-cycle return and reallocation of tag 3.
        idle(); ic_cmd = 2'd1; ic_addr = 'h30; m_resp = 4'd3;
        cyc("r036a"); commit();
        idle(); cyc("r036w"); commit();
        idle();
        dc_cmd = 2'd1; dc_addr = 'h300; m_resp = 4'd3;
        m_tag = 4'd3; m_data = 'h3333;
        cyc("r036b");
        check("r036.itag", i_tag, 3);
        check("r036.dtag0", d_tag, 0);
        commit();
        idle(); m_tag = 4'd3; m_data = 'h4444;
        cyc("r036c");
        check("r036.dtag", d_tag, 3);
        check("r036.ddata", d_data, 'h4444);
        commit();

        // Reset forgets in-flight loads.
        idle(); ic_cmd = 2'd1; ic_addr = 'h50; m_resp = 4'd5;
        cyc("r037a"); commit();
        idle();
        reset = 1'b1; ic_cmd = 2'd1; dc_cmd = 2'd1;
        dc_data = 'h77; m_resp = 4'd6; m_tag = 4'd3; m_data = 'h99;
        cyc("r037rst");
        check("r037.cmd", p_cmd, 0);
        check("r037.resp", {i_resp, d_resp}, 0);
        check("r037.err0", tag_err, 0);
        commit();
        idle(); m_tag = 4'd5; m_data = 'h5;
        cyc("r037r");
        check("r037.err", tag_err, 1);
        check("r037.itag", i_tag, 0);
        commit();

        // Rejected load leaves the table untouched.
        idle(); dc_cmd = 2'd1; dc_addr = 'h380; m_resp = 4'd0;
        cyc("r038a");
        check("r038.dresp", d_resp, 0);
        commit();
        idle(); m_tag = 4'd7; m_data = 'h7;
        cyc("r038r");
        check("r038.err", tag_err, 1);
        commit();

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            idle();
            reset   = ($urandom_range(0, 59) == 0);
            ic_cmd  = ($urandom_range(0, 9) == 0) ? 2'd3
                                                  : 2'($urandom_range(0, 1));
            ic_addr = $urandom;
            dc_cmd  = 2'($urandom_range(0, 3));
            dc_addr = $urandom;
            dc_data = {$urandom, $urandom};
            m_resp  = ($urandom_range(0, 2) == 0) ? 4'd0
                                                  : 4'($urandom_range(1, 15));
            m_tag   = ($urandom_range(0, 1) == 0) ? 4'd0
                                                  : 4'($urandom_range(1, 15));
            m_data  = {$urandom, $urandom};
            cyc("rnd");
            commit();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, address width.
REQ-002 Parameter STARVE_LIMIT, default 3, legal 1..7: consecutive icache denials before icache is forced priority.
REQ-003 Bus command encoding SHALL be BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; the value 3 SHALL be treated as BUS_NONE.
REQ-004 clock  in  1  system clock; one clock domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 icache2mem_command  in  2  icache request; only BUS_NONE or BUS_LOAD.
REQ-007 icache2mem_addr  in  XLEN  icache request address.
REQ-008 dcache2mem_command  in  2  dcache request; BUS_NONE, BUS_LOAD or BUS_STORE.
REQ-009 dcache2mem_addr  in  XLEN  dcache request address.
REQ-010 dcache2mem_data  in  64  dcache store data.
REQ-011 proc2mem_command  out  2  command to memory.
REQ-012 proc2mem_addr  out  XLEN  address to memory.
REQ-013 proc2mem_data  out  64  store data to memory.
REQ-014 mem2proc_response  in  4  accept tag for this cycle's command; 0 means rejected.
REQ-015 mem2proc_data  in  64  returning load data.
REQ-016 mem2proc_tag  in  4  tag of returning data; 0 means no return.
REQ-017 mem2icache_response, mem2icache_data, mem2icache_tag  out  4/64/4  routed to icache.
REQ-018 mem2dcache_response, mem2dcache_data, mem2dcache_tag  out  4/64/4  routed to dcache.
REQ-019 mem_tag_error  out  1  one-cycle pulse: return tag had no owner.

Function
REQ-020 Grant SHALL be combinational each cycle: dcache granted if it requests, unless icache requests and starve_cnt >= STARVE_LIMIT; else icache granted if it requests; else none.
REQ-021 Granted requester's command/address (dcache also data) SHALL drive proc2mem_*; no grant -> BUS_NONE, address 0, data 0.
REQ-022 mem2proc_response SHALL route to the granted requester's *_response; the other requester's response SHALL be 0 (retry).
REQ-023 starve_cnt (3 bits) SHALL increment, saturating at 7, when icache requests and is not granted; it SHALL clear when icache is granted or icache command is BUS_NONE.
REQ-024 Owner table: 16 entries of {valid, owner}; on a granted BUS_LOAD with response T != 0, entry T SHALL be written valid at the next edge, owner = granted requester.
REQ-025 Stores SHALL NOT allocate owner entries; rejected commands (response 0) SHALL NOT change the table.
REQ-026 On mem2proc_tag T != 0 with entry T valid: mem2proc_data and T SHALL drive the owner's *_data/*_tag in the same cycle, and entry T SHALL clear at the next edge; the non-owner SHALL see tag 0.
REQ-027 On mem2proc_tag T != 0 with entry T invalid: both *_tag outputs SHALL be 0 and mem_tag_error SHALL be 1 that cycle.
REQ-028 *_data outputs SHALL equal mem2proc_data whenever the corresponding *_tag is nonzero, and 0 otherwise.
REQ-029 Same-cycle return and allocation of tag T: the return SHALL route to the old owner, and the entry SHALL hold the new owner, valid, after the edge.
REQ-030 Tag 0 SHALL never be allocated or routed.

Reset
REQ-031 While reset=1: all outputs SHALL be 0 (proc2mem_command=BUS_NONE), no grant, and incoming responses and tags SHALL be ignored.
REQ-032 At an edge with reset=1: starve_cnt=0 and all owner entries invalid; loads in flight when reset is asserted SHALL be forgotten, and their later returns SHALL raise mem_tag_error.

Verification
REQ-033 Icache-only LOAD addr 0x100, response 1; 3 cycles later tag 1, data 0x12345678abcdef01 -> proc2mem_addr=0x100; mem2icache_response=1; then mem2icache_tag=1 with that data; mem2dcache_tag=0.
REQ-034 Both request LOADs every cycle, memory always returns response 0 -> dcache granted cycles 1-3; icache granted cycle 4 (starve_cnt=3); dcache granted cycle 5.
REQ-035 dcache STORE addr 0x200, data 0xAA, response 2 -> proc2mem_command=2, proc2mem_data=0xAA, mem2dcache_response=2; a later mem2proc_tag=2 raises mem_tag_error=1 and both *_tag outputs are 0.
REQ-036 icache load gets tag 3; later, same cycle: mem2proc_tag=3 and dcache load accepted with response 3 -> data routed to icache; the next return with tag 3 goes to dcache.
REQ-037 icache load outstanding on tag 5; reset pulsed 1 cycle; then mem2proc_tag=5 -> mem_tag_error=1, no routing. During reset, all outputs are 0 despite active requests.
REQ-038 Memory rejects a dcache LOAD (response 0) -> mem2dcache_response=0, no table change; a later return with that address's would-be tag raises mem_tag_error.
